// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns stores onto a 32-bit data bus, extends load
// data into a WB-stage register, stalls the pipeline on slow memory, counts activity.
module mem_access_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_load,
  input  logic                 mem_store,
  input  logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_calculated_result_in,
  input  logic [31:0]          mem_store_data,
  input  logic                 mem_reg_file_in,
  input  logic [4:0]           mem_rd_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_ready,
  input  logic [31:0]          dmem_rdata,
  output logic                 mem_wb_load,
  output logic                 mem_wb_reg_file,
  output logic [31:0]          mem_calculated_result,
  output logic [4:0]           mem_wb_rd,
  output logic [31:0]          mem_read_data,
  output logic                 mem_stall,
  output logic                 mem_misaligned,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] access_count
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state;
  logic [1:0]           off;
  logic                 is_byte, is_half, aligned, access, valid, done;
  logic [31:0]          rdata_p1;
  logic [CNT_WIDTH-1:0] stall_cnt, access_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sel,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {sel, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // funct3[1:0] selects the size; 011/110/111 fall through to word
  assign off     = mem_calculated_result_in[1:0];
  assign is_byte = (mem_funct3[1:0] == 2'b00);
  assign is_half = (mem_funct3[1:0] == 2'b01);
  assign aligned = is_byte | (is_half & ~off[0]) | (~is_byte & ~is_half & (off == 2'b00));
  assign access  = mem_load | mem_store;
  assign valid   = access & aligned;

  // While in WAIT the upstream stages are frozen, so the inputs still describe the access
  assign dmem_req       = ~rst & ((state == S_WAIT) | valid);
  assign mem_stall      = dmem_req & ~dmem_ready;
  assign done           = dmem_req & dmem_ready;
  assign mem_misaligned = access & ~aligned;

  assign dmem_we   = mem_store;
  assign dmem_addr = {mem_calculated_result_in[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_store_data;
    if (mem_store) begin
      if (is_byte) begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{mem_store_data[7:0]}};
      end else if (is_half) begin
        dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{mem_store_data[15:0]}};
      end
    end
  end

  assign mem_wb_load           = mem_load & ~mem_stall & ~mem_misaligned;
  assign mem_wb_reg_file       = mem_reg_file_in & ~mem_stall & ~mem_misaligned;
  assign mem_calculated_result = mem_calculated_result_in;
  assign mem_wb_rd             = mem_rd_in;

  // MEM -> WB boundary: FSM, counters and the extended load word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      stall_cnt  <= '0;
      access_cnt <= '0;
      rdata_p1   <= '0;
    end else begin
      state <= mem_stall ? S_WAIT : S_IDLE;
      if (mem_stall) stall_cnt <= sat_inc(stall_cnt);
      if (done) access_cnt <= sat_inc(access_cnt);
      if (done & mem_load) rdata_p1 <= load_ext(dmem_rdata, off, mem_funct3);
    end
  end

  assign mem_read_data = rdata_p1;
  assign stall_count   = stall_cnt;
  assign access_count  = access_cnt;

endmodule
